// File: rtl/homogenization_seq.sv
// homogenization_seq: sequential IPM-RED homogenization stage.
// Folds the delta chain over GF(2^8) using MULS gmul8 lanes per cycle and
// presents the homogenized vector c behind a valid/ready handshake.
// Optional build macro: HOMOG_CLEAR_EN (clear operands, delta and c on the
// output handshake so no share values linger in the registers).
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready high
// RUN   | folding up to MULS delta terms per cycle
// DONE  | c valid, holding until out_ready

module gmul8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] p
);
    logic [7:0] xs;

    // Shift-and-add multiply, reducing by the AES polynomial 0x11B.
    always_comb begin
        p  = '0;
        xs = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ xs;
            xs = {xs[6:0], 1'b0} ^ (xs[7] ? 8'h1B : 8'h00);
        end
    end
endmodule

module homogenization_seq #(
    parameter int V    = 3,
    parameter int MULS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [V*8-1:0]     l2,
    input  logic [(V-1)*8-1:0] a,
    input  logic [(V-1)*8-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [V*8-1:0]     c,
    output logic               busy
);
    localparam int NT   = V - 2;
    localparam int M    = (NT < 1) ? 1 : (MULS < 1) ? 1 : (MULS > NT) ? NT : MULS;
    localparam int ITER = (NT == 0) ? 0 : (NT + M - 1) / M;
    localparam int IW   = $clog2(ITER + 2);
    localparam int JW   = $clog2(V + M + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [V*8-1:0]       l2_q;
    logic [(V-1)*8-1:0]   a_q, b_q;
    logic [7:0]           delta_q, delta_fold;
    logic [JW-1:0]        j_q;
    logic [IW-1:0]        iter_q;
    logic [V*8-1:0]       c_q;
    logic [7:0]           opx [M];
    logic [7:0]           opy [M];
    logic [7:0]           prod [M];
    logic                 unused_regs;

    // Byte 0 of l2/b and, for V=2, the whole index path never reach a lane.
    assign unused_regs = ^{l2_q[15:0], b_q[7:0], a_q, j_q};

    function automatic logic [V*8-1:0] map_c(input logic [(V-1)*8-1:0] av,
                                             input logic [7:0] d);
        logic [V*8-1:0] r;
        r        = '0;
        r[7:0]   = av[7:0];
        r[15:8]  = d;
        for (int j = 1; j <= NT; j++) r[8*(j+1) +: 8] = av[8*j +: 8];
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = (ITER == 0) ? DONE : RUN;
            end
            RUN: begin
                if (iter_q == IW'(1)) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane operand select: lane m handles term j_q+m; lanes past V-2 see zero.
    always_comb begin
        for (int m = 0; m < M; m++) begin
            opx[m] = '0;
            opy[m] = '0;
            for (int k = 1; k <= NT; k++) begin
                if (int'(j_q) + m == k) begin
                    opx[m] = l2_q[8*(k+1) +: 8];
                    opy[m] = a_q[8*k +: 8] ^ b_q[8*k +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < M; g++) begin : g_lane
        gmul8 u_gmul8 (.x(opx[g]), .y(opy[g]), .p(prod[g]));
    end

    // XOR the lane products into the running delta.
    always_comb begin
        delta_fold = delta_q;
        for (int m = 0; m < M; m++) delta_fold = delta_fold ^ prod[m];
    end

    // Operand capture, delta iteration and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l2_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            delta_q <= '0;
            j_q     <= '0;
            iter_q  <= '0;
            c_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        l2_q    <= l2;
                        a_q     <= a;
                        b_q     <= b;
                        delta_q <= b[7:0];
                        j_q     <= JW'(1);
                        iter_q  <= IW'(ITER);
                        if (ITER == 0) c_q <= map_c(a, b[7:0]);
                    end
                end
                RUN: begin
                    delta_q <= delta_fold;
                    j_q     <= j_q + JW'(M);
                    iter_q  <= iter_q - IW'(1);
                    if (iter_q == IW'(1)) c_q <= map_c(a_q, delta_fold);
                end
                DONE: begin
`ifdef HOMOG_CLEAR_EN
                    if (out_ready) begin
                        l2_q    <= '0;
                        a_q     <= '0;
                        b_q     <= '0;
                        delta_q <= '0;
                        c_q     <= '0;
                    end
`else
                    c_q <= c_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign c = c_q;

endmodule

// File: tb/tb_homogenization_seq.sv
// Self-checking bench for homogenization_seq: several V/MULS instances driven
// with random operand sets and compared against a GF(2^8) reference model.
module tb_homogenization_seq;
    localparam int NI = 6;
    localparam int VS [NI] = '{3, 2, 6, 6, 6, 8};
    localparam int MS [NI] = '{1, 1, 1, 2, 4, 1};

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NI-1:0]         in_valid, out_ready;
    logic [NI-1:0]         in_ready, out_valid, busy;
    logic [NI-1:0][63:0]   l2_bus, a_bus, b_bus, c_bus;
    int                    n_chk = 0;
    int                    n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [VS[g]*8-1:0] c_loc;
        homogenization_seq #(.V(VS[g]), .MULS(MS[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .l2        (l2_bus[g][VS[g]*8-1:0]),
            .a         (a_bus[g][(VS[g]-1)*8-1:0]),
            .b         (b_bus[g][(VS[g]-1)*8-1:0]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .c         (c_loc),
            .busy      (busy[g])
        );
        assign c_bus[g] = 64'(c_loc);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Polynomial product then long division by 0x11B.
    function automatic logic [7:0] gf_ref(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (15'(x) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [63:0] ref_c(input int v, input logic [63:0] l2v,
                                          input logic [63:0] av, input logic [63:0] bv);
        logic [7:0]  d;
        logic [63:0] r;
        d = bv[7:0];
        for (int j = 1; j <= v - 2; j++)
            d = d ^ gf_ref(l2v[8*(j+1) +: 8], av[8*j +: 8] ^ bv[8*j +: 8]);
        r = '0;
        r[7:0]  = av[7:0];
        r[15:8] = d;
        for (int j = 1; j <= v - 2; j++) r[8*(j+1) +: 8] = av[8*j +: 8];
        return r;
    endfunction

    function automatic int ref_lat(input int v, input int m);
        if (v == 2) return 1;
        return (v - 2 + m - 1) / m + 1;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // One full transaction with out_ready held high; checks latency, c and the
    // state one cycle after the output handshake.
    task automatic run_op(input int i, input logic [63:0] l2v, input logic [63:0] av,
                          input logic [63:0] bv, input logic [63:0] c_exp,
                          input int lat_exp, input string tag);
        int lat;
        check_val({tag, "_in_ready"}, 64'(in_ready[i]), 64'd1);
        l2_bus[i]   = l2v;
        a_bus[i]    = av;
        b_bus[i]    = bv;
        in_valid[i] = 1'b1;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        l2_bus[i]   = rand64();
        a_bus[i]    = rand64();
        b_bus[i]    = rand64();
        lat = 1;
        while (!out_valid[i] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_lat"}, 64'(lat), 64'(lat_exp));
        check_val({tag, "_c"}, c_bus[i], c_exp);
        @(posedge clk); #1;
        check_val({tag, "_post_ovalid"}, 64'(out_valid[i]), 64'd0);
        check_val({tag, "_post_ready"}, 64'(in_ready[i]), 64'd1);
`ifdef HOMOG_CLEAR_EN
        check_val({tag, "_post_c"}, c_bus[i], 64'd0);
`else
        check_val({tag, "_post_c"}, c_bus[i], c_exp);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] l2v, av, bv, cexp;
        int lat;
        int seen_ov;
        in_valid  = '0;
        out_ready = '1;
        l2_bus    = '0;
        a_bus     = '0;
        b_bus     = '0;

        // Reset state
        #12;
        check_val("rst_in_ready", 64'(in_ready), 64'h3F);
        check_val("rst_out_valid", 64'(out_valid), 64'h0);
        check_val("rst_busy", 64'(busy), 64'h0);
        check_val("rst_c0", c_bus[0], 64'h0);
        check_val("rst_c5", c_bus[5], 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        run_op(0, 64'h02_7A_C3, 64'h80_11, 64'h00_05, 64'h80_1E_11, 2, "dir_v3");
        run_op(1, 64'h5A_96, 64'h3C, 64'hA5, 64'hA5_3C, 1, "dir_v2");

        // Random vectors on every instance
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 6; n++) begin
                l2v = rand64();
                av  = rand64();
                bv  = rand64();
                run_op(i, l2v, av, bv, ref_c(VS[i], l2v, av, bv), ref_lat(VS[i], MS[i]),
                       $sformatf("rnd_v%0d_m%0d_%0d", VS[i], MS[i], n));
            end
        end

        // Back-pressure in DONE on the V=3 instance
        out_ready[0] = 1'b0;
        l2v = rand64(); av = rand64(); bv = rand64();
        cexp = ref_c(3, l2v, av, bv);
        l2_bus[0] = l2v; a_bus[0] = av; b_bus[0] = bv;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 1;
        while (!out_valid[0] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("bp_lat", 64'(lat), 64'd2);
        check_val("bp_c", c_bus[0], cexp);
        for (int k = 0; k < 10; k++) begin
            in_valid[0] = 1'b1;
            l2_bus[0] = rand64(); a_bus[0] = rand64(); b_bus[0] = rand64();
            @(posedge clk); #1;
            check_val($sformatf("bp_hold_ovalid_%0d", k), 64'(out_valid[0]), 64'd1);
            check_val($sformatf("bp_hold_ready_%0d", k), 64'(in_ready[0]), 64'd0);
            check_val($sformatf("bp_hold_c_%0d", k), c_bus[0], cexp);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check_val("bp_release_ready", 64'(in_ready[0]), 64'd1);
        check_val("bp_release_ovalid", 64'(out_valid[0]), 64'd0);
        check_val("bp_release_busy", 64'(busy[0]), 64'd0);

        // Reset in the middle of RUN on the V=8 instance
        l2v = rand64(); av = rand64(); bv = rand64();
        l2_bus[5] = l2v; a_bus[5] = av; b_bus[5] = bv;
        in_valid[5] = 1'b1;
        @(posedge clk); #1;
        in_valid[5] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("mid_busy_before", 64'(busy[5]), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ovalid", 64'(out_valid[5]), 64'd0);
        check_val("mid_rst_busy", 64'(busy[5]), 64'd0);
        check_val("mid_rst_c", c_bus[5], 64'd0);
        check_val("mid_rst_ready", 64'(in_ready[5]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen_ov = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid[5]) seen_ov++;
        end
        check_val("mid_no_output", 64'(seen_ov), 64'd0);
        l2v = rand64(); av = rand64(); bv = rand64();
        run_op(5, l2v, av, bv, ref_c(8, l2v, av, bv), ref_lat(8, 1), "after_rst_v8");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
